// File: rtl/exp2_pkg.sv
// Shared constants, state encoding and the 2^(2^-k) table for the exp2_fixed antilog unit.
package exp2_pkg;

    localparam int F_BITS     = 16;
    localparam int ACC_W      = F_BITS + 2;   // Q2.16 accumulator
    localparam int C_W        = F_BITS + 1;   // Q1.16 multiplicand
    localparam int MUL_CYCLES = C_W + 1;      // setup + one cycle per multiplier bit

    localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1 << F_BITS);
    localparam logic [C_W-1:0]   C_ONE   = C_W'(1 << F_BITS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        SCALE,
        FIN,
        HOLD
    } state_e;

    // round(2^(2^-k) * 65536) for k = 1..16
    function automatic logic [C_W-1:0] exp2_lut(input logic [4:0] k);
        logic [C_W-1:0] c;
        case (k)
            5'd1:    c = 17'd92682;
            5'd2:    c = 17'd77936;
            5'd3:    c = 17'd71468;
            5'd4:    c = 17'd68438;
            5'd5:    c = 17'd66971;
            5'd6:    c = 17'd66250;
            5'd7:    c = 17'd65892;
            5'd8:    c = 17'd65714;
            5'd9:    c = 17'd65625;
            5'd10:   c = 17'd65580;
            5'd11:   c = 17'd65558;
            5'd12:   c = 17'd65547;
            5'd13:   c = 17'd65542;
            5'd14:   c = 17'd65539;
            5'd15:   c = 17'd65537;
            5'd16:   c = 17'd65537;
            default: c = C_ONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/exp2_serial_mul.sv
// Shift-add multiplier: one setup cycle then one cycle per multiplier bit; returns (a*b)>>16.
module exp2_serial_mul
    import exp2_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic [ACC_W-1:0] a_i,
    input  logic [C_W-1:0]   b_i,
    output logic             done_o,
    output logic [ACC_W-1:0] p_o
);

    localparam int P_W = ACC_W + C_W;

    logic [4:0]     cnt_q, cnt_d;
    logic [P_W-1:0] mcand_q, mcand_d;
    logic [P_W-1:0] prod_q, prod_d, prod_nxt;
    logic [C_W-1:0] mplier_q, mplier_d;

    always_comb begin
        prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (en_i) begin
            if (cnt_q == 5'd0) begin
                mcand_d  = P_W'(a_i);
                mplier_d = b_i;
                prod_d   = '0;
                cnt_d    = 5'd1;
            end else begin
                prod_d   = prod_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = (cnt_q == 5'(MUL_CYCLES - 1)) ? 5'd0 : cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    // Result is taken from the final partial sum so the pass ends exactly on the last bit.
    assign done_o = en_i && (cnt_q == 5'(MUL_CYCLES - 1));
    assign p_o    = ACC_W'(prod_nxt >> F_BITS);

endmodule

// File: rtl/exp2_fixed.sv
// Iterative 2^x for a signed Q(M.N) exponent, unsigned Q(OUT_I.N) result with saturation.
// Define EXP2_ROUND_EN to round half-up in the final right shift instead of truncating.
module exp2_fixed
    import exp2_pkg::*;
#(
    parameter int M     = 2,
    parameter int N     = 5,
    parameter int OUT_I = 8
)(
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [M+N:0]       number,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [OUT_I+N-1:0] expNumber,
    output logic               sat_o,
    output logic               valid_o,
    input  logic               ready_i
);

    localparam int O_W  = OUT_I + N;
    localparam int SW   = M + 7;
    localparam int RW_A = ACC_W + (1 << M) + N;
    localparam int RW   = (RW_A > O_W + 1) ? RW_A : O_W + 1;
    localparam logic signed [SW-1:0] S_OFF = SW'(N - F_BITS);

    state_e           state_q, state_d;
    logic [M+N:0]     num_q, num_d;
    logic [N-1:0]     fsh_q, fsh_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]       k_q, k_d;
    logic [RW-1:0]    r_q, r_d, r_w;
    logic [O_W-1:0]   exp_q, exp_d;
    logic             ready_q, ready_d, valid_q, valid_d, sat_q, sat_d;

    logic             mul_en, mul_done, ovf;
    logic [ACC_W-1:0] mul_p;
    logic [C_W-1:0]   mul_b;
    logic signed [SW-1:0] s_w;
    logic [SW-1:0]    sh_w;
`ifdef EXP2_ROUND_EN
    logic             rnd_b;
`endif

    assign mul_en = (state_q == MUL);
    assign mul_b  = fsh_q[N-1] ? exp2_lut(k_q) : C_ONE;

    exp2_serial_mul u_mul (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (mul_en),
        .a_i    (acc_q),
        .b_i    (mul_b),
        .done_o (mul_done),
        .p_o    (mul_p)
    );

    // s = floor(x) + N - 16 aligns the Q2.16 mantissa to the Q(OUT_I.N) output grid.
    always_comb begin
        s_w  = $signed({{(SW-M-1){num_q[M+N]}}, num_q[M+N:N]}) + S_OFF;
        sh_w = s_w[SW-1] ? $unsigned(-s_w) : $unsigned(s_w);
        r_w  = RW'(acc_q) << sh_w;
`ifdef EXP2_ROUND_EN
        rnd_b = 1'b0;
`endif
        if (s_w[SW-1]) begin
`ifdef EXP2_ROUND_EN
            rnd_b = |((RW'(acc_q) >> (sh_w - SW'(1))) & RW'(1));
            r_w   = (RW'(acc_q) >> sh_w) + RW'(rnd_b);
`else
            r_w   = RW'(acc_q) >> sh_w;
`endif
        end
    end

    assign ovf = (r_q >> O_W) != '0;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        fsh_d   = fsh_q;
        acc_d   = acc_q;
        k_d     = k_q;
        r_d     = r_q;
        exp_d   = exp_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (valid_i && ready_q) begin
                    num_d   = number;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                fsh_d   = num_q[N-1:0];
                acc_d   = ACC_ONE;
                k_d     = 5'd1;
                state_d = MUL;
            end
            MUL: begin
                if (mul_done) begin
                    acc_d = mul_p;
                    fsh_d = fsh_q << 1;
                    k_d   = k_q + 5'd1;
                    if (k_q == 5'(N)) state_d = SCALE;
                end
            end
            SCALE: begin
                r_d     = r_w;
                state_d = FIN;
            end
            FIN: begin
                exp_d   = ovf ? '1 : r_q[O_W-1:0];
                sat_d   = ovf;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            num_q   <= '0;
            fsh_q   <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            r_q     <= '0;
            exp_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            fsh_q   <= fsh_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            r_q     <= r_d;
            exp_q   <= exp_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o   = ready_q;
    assign valid_o   = valid_q;
    assign sat_o     = sat_q;
    assign expNumber = exp_q;

endmodule

// File: tb/tb_exp2_fixed.sv
// Directed bench for exp2_fixed: two instances (OUT_I=8 and OUT_I=3) driven in lockstep.
module tb_exp2_fixed;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic [7:0]  number = '0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic        ready_o, valid_o, sat_o;
    logic [12:0] expNumber;
    logic        ready3, valid3, sat3;
    logic [7:0]  exp3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exp2_fixed #(.M(2), .N(5), .OUT_I(8)) dut (
        .clk_i     (clk),
        .rstn_i    (rstn_i),
        .number    (number),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .expNumber (expNumber),
        .sat_o     (sat_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i)
    );

    exp2_fixed #(.M(2), .N(5), .OUT_I(3)) dut3 (
        .clk_i     (clk),
        .rstn_i    (rstn_i),
        .number    (number),
        .valid_i   (valid_i),
        .ready_o   (ready3),
        .expNumber (exp3),
        .sat_o     (sat3),
        .valid_o   (valid3),
        .ready_i   (ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // exp_v is the unsaturated Q.5 result; the OUT_I=3 copy clips it at 255.
    task automatic xact(input string tag, input logic [7:0] num, input int exp_v);
        int guard;
        int lat;
        int e3;
        guard = 0;
        while (ready_o !== 1'b1 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, "_rdy"}, 32'(ready_o), 1);
        number  = num;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        e3 = (exp_v > 255) ? 255 : exp_v;
        chk({tag, "_lat"},  32'(lat), 93);
        chk({tag, "_val"},  32'(expNumber), 32'(exp_v));
        chk({tag, "_sat"},  32'(sat_o), 0);
        chk({tag, "_val3"}, 32'(exp3), 32'(e3));
        chk({tag, "_sat3"}, 32'(sat3), (exp_v > 255) ? 1 : 0);
        chk({tag, "_v3"},   32'(valid3), 1);
        @(posedge clk); #1;
        chk({tag, "_drop"}, 32'(valid_o), 0);
    endtask

    initial begin
        int   lat;
        int   guard;
        logic ok;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_sat",   32'(sat_o), 0);
        chk("rst_exp",   32'(expNumber), 0);
        rstn_i = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", 32'(ready_o), 1);

        xact("x00", 8'h00, 32);
        xact("x20", 8'h20, 64);
        xact("xE0", 8'hE0, 16);
        xact("x80", 8'h80, 2);
        xact("x10", 8'h10, 45);
        xact("x08", 8'h08, 38);
        xact("x7F", 8'h7F, 501);
        xact("x60", 8'h60, 256);
`ifdef EXP2_ROUND_EN
        xact("xF0", 8'hF0, 23);
        xact("x9F", 8'h9F, 4);
`else
        xact("xF0", 8'hF0, 22);
        xact("x9F", 8'h9F, 3);
`endif

        // Backpressure: valid_i kept busy with a different word the whole time.
        ready_i = 1'b0;
        number  = 8'h10;
        valid_i = 1'b1;
        @(posedge clk); #1;
        number = 8'h7F;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            valid_i = ~valid_i;
        end
        chk("bp_lat", 32'(lat), 93);
        chk("bp_val", 32'(expNumber), 45);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            valid_i = ~valid_i;
            @(posedge clk); #1;
            if (expNumber !== 13'd45 || valid_o !== 1'b1 || ready_o !== 1'b0 || sat_o !== 1'b0)
                ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 1);
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(valid_o), 0);
        chk("bp_release_ready", 32'(ready_o), 1);
        ok = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (valid_o !== 1'b0) ok = 1'b0;
        end
        chk("bp_no_ghost", 32'(ok), 1);

        // Reset during MUL drops the pending result.
        guard = 0;
        while (ready_o !== 1'b1 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        number  = 8'h20;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rstn_i = 1'b0;
        @(posedge clk); #1;
        chk("mrst_ready", 32'(ready_o), 0);
        chk("mrst_valid", 32'(valid_o), 0);
        chk("mrst_sat",   32'(sat_o), 0);
        chk("mrst_exp",   32'(expNumber), 0);
        rstn_i = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (valid_o !== 1'b0) ok = 1'b0;
        end
        chk("mrst_no_valid", 32'(ok), 1);
        xact("post_rst", 8'h7F, 501);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
